img_mem_arbiter: RTL and testbench
==================================

# img_mem_arbiter

Shares the single-port image RAM, which holds the original and processed images back to back, between the processor data port and the display scanner. CPU accesses use the system address map (original image region from 120, processed image region from 160120). Display accesses use a pixel index plus an image select. The block sits between the I/O address decoder / CPU load-store path and the image RAM. It issues at most one RAM access per cycle and guarantees that neither requester starves.

## Interface
- ADDR_W, 24, CPU byte-address width
- DATA_W, 8, pixel / data width
- ORIG_BASE, 120, first CPU address of the original image
- IMG_SIZE, 160000, pixels per image; processed region starts at ORIG_BASE+IMG_SIZE
- RAM_AW, 19, RAM address width (must hold 2*IMG_SIZE)
- IDX_W, 18, display pixel-index width
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- cpu_req  input  1  CPU access request, held until cpu_ack
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_W  system address
- cpu_wdata  input  DATA_W  write data
- cpu_rdata  output  DATA_W  read data, valid while cpu_ack
- cpu_ack  output  1  one-cycle completion pulse
- cpu_err  output  1  qualifies cpu_ack: address outside both image regions
- disp_req  input  1  display read request, held until disp_valid
- disp_sel  input  1  0 = original image, 1 = processed image
- disp_idx  input  IDX_W  pixel index
- disp_rdata  output  DATA_W  pixel, valid while disp_valid
- disp_valid  output  1  one-cycle completion pulse
- ram_en, ram_we  output  1  RAM strobe / write enable
- ram_addr  output  RAM_AW  RAM word address
- ram_wdata  output  DATA_W  RAM write data
- ram_rdata  input  DATA_W  synchronous RAM read data, one cycle after ram_en

## Operation
- The FSM (state register) has three states:
  - S_IDLE: no access in flight.
  - S_CPU: CPU access issued last cycle.
  - S_DISP: display access issued last cycle.
- Eligibility: a port is not eligible in the cycle its ack/valid is asserted. This prevents re-issuing a request that the requester has not yet dropped.
  - CPU is eligible = cpu_req and state != S_CPU.
  - Display is eligible = disp_req and state != S_DISP.
- Grant rule, evaluated every cycle:
  - Both ports eligible (only possible from S_IDLE): display wins.
  - Otherwise the single eligible port wins.
  - Neither eligible: next state is S_IDLE.
  - Winner's state is next: CPU → S_CPU, display → S_DISP.
- CPU mapping:
  - In range = ORIG_BASE ≤ cpu_addr < ORIG_BASE+2*IMG_SIZE (120 … 320119).
  - ram_addr = cpu_addr − ORIG_BASE; the subtraction is done at ADDR_W and truncated to RAM_AW.
  - Out of range: the grant still occurs and occupies the slot, but ram_en = 0. The ack then carries cpu_err = 1 and cpu_rdata = 0. Out-of-range writes are discarded.
- Display mapping:
  - ram_addr = disp_idx + (disp_sel ? IMG_SIZE : 0), computed at RAM_AW.
  - disp_idx ≥ IMG_SIZE: no ram_en, and disp_rdata = 0.
- Display accesses are always reads; ram_we = 0.
- ram_en, ram_we, ram_addr and ram_wdata are driven combinationally in the grant cycle. They are 0 when nothing is granted.
- A request held continuously on both ports alternates grants every cycle, so each port gets one access per two cycles. Neither port can starve.

## Timing
- Latency: grant in cycle N → ack/valid in cycle N+1.
  - For reads, rdata in cycle N+1 is ram_rdata, or 0 when out of range.
  - For writes, cpu_ack in N+1 indicates the write committed at the edge ending N.
- cpu_ack, cpu_err, disp_valid and the in-range flags are registered. cpu_rdata and disp_rdata are a combinational mux of ram_rdata, gated to 0 when not valid.
- A requester may present a new request in the cycle after its ack. It is granted no earlier than that cycle.
- Reset values: state S_IDLE. cpu_ack, cpu_err, disp_valid, cpu_rdata, disp_rdata, ram_en and ram_we are all 0.
- Reset mid-operation: an in-flight access completes no ack/valid. A write whose edge already passed has landed in RAM. On the first cycle after reset release, both ports are eligible.
- Dropping a request before its ack is a protocol violation. The grant still completes and is acked.

## Structure
- Package img_mem_pkg holds:
  - The arb_state_t enum (S_IDLE, S_CPU, S_DISP).
  - Localparams for the default ORIG_BASE, IMG_SIZE, PROC_BASE (= 160120) and REGION_END (= 320120).
- One sub-module, img_addr_map: purely combinational. It takes cpu_addr / disp_sel / disp_idx and produces the RAM address plus the in-range flag for each port.

## Test plan
- CPU read at cpu_addr 120 with RAM[0] = 0x5A: ram_addr = 0 in grant cycle; next cycle cpu_ack = 1, cpu_rdata = 0x5A, cpu_err = 0.
- CPU write 0x33 at cpu_addr 160120: ram_we = 1, ram_addr = 160000, then cpu_ack. A following display read with disp_sel = 1, disp_idx = 0 returns disp_rdata = 0x33.
- cpu_req and disp_req raised together from S_IDLE and held for 8 cycles: display is granted first, then grants alternate. Exactly 4 disp_valid and 4 cpu_ack pulses occur, never in the same port on consecutive cycles.
- cpu_addr = 96, then cpu_addr = 320120: no ram_en in either case; cpu_ack with cpu_err = 1 and cpu_rdata = 0; RAM contents unchanged.
- disp_idx = 160000: no ram_en; disp_valid = 1 with disp_rdata = 0.
- rst asserted low in the cycle after a CPU read grant: no cpu_ack, all outputs 0. After release, a held cpu_req is granted on the first cycle.

Source files
------------

// File: rtl/img_mem_pkg.sv
// Shared types and default memory-map constants for the image RAM arbiter.
package img_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU,
    S_DISP
  } arb_state_t;

  localparam int unsigned ORIG_BASE_DEF  = 120;
  localparam int unsigned IMG_SIZE_DEF   = 160000;
  localparam int unsigned PROC_BASE_DEF  = ORIG_BASE_DEF + IMG_SIZE_DEF;      // 160120
  localparam int unsigned REGION_END_DEF = ORIG_BASE_DEF + 2 * IMG_SIZE_DEF;  // 320120

endpackage

// File: rtl/img_addr_map.sv
// Combinational translation of CPU system addresses and display pixel indices
// into image-RAM word addresses, with an in-range flag per port.
module img_addr_map
  import img_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned RAM_AW    = 19,
  parameter int unsigned IDX_W     = 18,
  parameter int unsigned ORIG_BASE = ORIG_BASE_DEF,
  parameter int unsigned IMG_SIZE  = IMG_SIZE_DEF
) (
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              disp_sel_i,
  input  logic [IDX_W-1:0]  disp_idx_i,
  output logic [RAM_AW-1:0] cpu_ram_addr_o,
  output logic              cpu_in_range_o,
  output logic [RAM_AW-1:0] disp_ram_addr_o,
  output logic              disp_in_range_o
);

  localparam logic [ADDR_W-1:0] CpuBase = ADDR_W'(ORIG_BASE);
  localparam int unsigned       CpuEnd  = ORIG_BASE + 2 * IMG_SIZE;

  logic [ADDR_W-1:0] cpu_off;

  // Both images sit back to back in RAM; the processed one starts at IMG_SIZE.
  always_comb begin
    cpu_off         = cpu_addr_i - CpuBase;
    cpu_ram_addr_o  = cpu_off[RAM_AW-1:0];
    cpu_in_range_o  = (32'(cpu_addr_i) >= ORIG_BASE) && (32'(cpu_addr_i) < CpuEnd);
    disp_ram_addr_o = RAM_AW'(disp_idx_i) + (disp_sel_i ? RAM_AW'(IMG_SIZE) : '0);
    disp_in_range_o = 32'(disp_idx_i) < IMG_SIZE;
  end

endmodule

// File: rtl/img_mem_arbiter.sv
// Single-port image RAM arbiter between the CPU data port and the display
// scanner. One access per cycle; a port that was just served yields the next
// slot, so continuously held requests alternate and neither side starves.
module img_mem_arbiter
  import img_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ORIG_BASE = ORIG_BASE_DEF,
  parameter int unsigned IMG_SIZE  = IMG_SIZE_DEF,
  parameter int unsigned RAM_AW    = 19,
  parameter int unsigned IDX_W     = 18
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic              cpu_err_o,
  input  logic              disp_req_i,
  input  logic              disp_sel_i,
  input  logic [IDX_W-1:0]  disp_idx_i,
  output logic [DATA_W-1:0] disp_rdata_o,
  output logic              disp_valid_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  arb_state_t        state_q, state_d;
  logic              cpu_grant, disp_grant;
  logic              cpu_in_range, disp_in_range;
  logic [RAM_AW-1:0] cpu_ram_addr, disp_ram_addr;
  logic              cpu_ack_q, cpu_err_q, cpu_rd_ok_q;
  logic              disp_valid_q, disp_rd_ok_q;

  img_addr_map #(
    .ADDR_W   (ADDR_W),
    .RAM_AW   (RAM_AW),
    .IDX_W    (IDX_W),
    .ORIG_BASE(ORIG_BASE),
    .IMG_SIZE (IMG_SIZE)
  ) u_addr_map (
    .cpu_addr_i     (cpu_addr_i),
    .disp_sel_i     (disp_sel_i),
    .disp_idx_i     (disp_idx_i),
    .cpu_ram_addr_o (cpu_ram_addr),
    .cpu_in_range_o (cpu_in_range),
    .disp_ram_addr_o(disp_ram_addr),
    .disp_in_range_o(disp_in_range)
  );

  // Grant: the port served last cycle is ineligible; display wins a tie.
  // Held off during reset so the RAM sees no strobe.
  always_comb begin
    disp_grant = rst_ni && disp_req_i && (state_q != S_DISP);
    cpu_grant  = rst_ni && cpu_req_i && (state_q != S_CPU) && !disp_grant;
    state_d    = disp_grant ? S_DISP : (cpu_grant ? S_CPU : S_IDLE);
  end

  // RAM strobe for the winner; out-of-range grants take the slot but no access.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (disp_grant && disp_in_range) begin
      ram_en_o   = 1'b1;
      ram_addr_o = disp_ram_addr;
    end else if (cpu_grant && cpu_in_range) begin
      ram_en_o   = 1'b1;
      ram_we_o   = cpu_we_i;
      ram_addr_o = cpu_ram_addr;
      if (cpu_we_i) ram_wdata_o = cpu_wdata_i;
    end
  end

  // Arbiter state plus registered completion pulses and read-data qualifiers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cpu_ack_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rd_ok_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_rd_ok_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_ack_q    <= cpu_grant;
      cpu_err_q    <= cpu_grant && !cpu_in_range;
      cpu_rd_ok_q  <= cpu_grant && cpu_in_range && !cpu_we_i;
      disp_valid_q <= disp_grant;
      disp_rd_ok_q <= disp_grant && disp_in_range;
    end
  end

  // Read data straight from the RAM, forced to zero unless a good read completes.
  always_comb begin
    cpu_ack_o    = cpu_ack_q;
    cpu_err_o    = cpu_err_q;
    disp_valid_o = disp_valid_q;
    cpu_rdata_o  = cpu_rd_ok_q ? ram_rdata_i : '0;
    disp_rdata_o = disp_rd_ok_q ? ram_rdata_i : '0;
  end

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Bench for img_mem_arbiter: behavioural RAM, directed checks with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_img_mem_arbiter;

  localparam int unsigned OrigBase = 120;
  localparam int unsigned ImgSize  = 160000;
  localparam int unsigned RegEnd   = OrigBase + 2 * ImgSize;
  localparam int unsigned MemWords = 1 << 19;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [23:0] cpu_addr_i = '0;
  logic [7:0]  cpu_wdata_i = '0;
  logic [7:0]  cpu_rdata_o;
  logic        cpu_ack_o, cpu_err_o;
  logic        disp_req_i = 1'b0, disp_sel_i = 1'b0;
  logic [17:0] disp_idx_i = '0;
  logic [7:0]  disp_rdata_o;
  logic        disp_valid_o;
  logic        ram_en_o, ram_we_o;
  logic [18:0] ram_addr_o;
  logic [7:0]  ram_wdata_o;
  logic [7:0]  ram_rdata_i = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int ram_wr_cnt = 0;

  logic [7:0] mem    [MemWords];
  logic [7:0] shadow [MemWords];

  img_mem_arbiter dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_ack_o   (cpu_ack_o),
    .cpu_err_o   (cpu_err_o),
    .disp_req_i  (disp_req_i),
    .disp_sel_i  (disp_sel_i),
    .disp_idx_i  (disp_idx_i),
    .disp_rdata_o(disp_rdata_o),
    .disp_valid_o(disp_valid_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous single-port RAM.
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        mem[ram_addr_o] <= ram_wdata_o;
        ram_wr_cnt++;
      end else begin
        ram_rdata_i <= mem[ram_addr_o];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a port just completed (ack/valid this cycle) may not be
  // granted; otherwise display first. Expectations for the next cycle are
  // queued as pending completions.
  logic       pend_cpu = 1'b0, pend_cpu_err = 1'b0, pend_cpu_chk = 1'b0;
  logic [7:0] pend_cpu_data = '0;
  logic       pend_disp = 1'b0;
  logic [7:0] pend_disp_data = '0;

  always @(negedge clk_i) begin : model
    logic g_disp, g_cpu, c_in, d_in, exp_en, exp_we;
    int unsigned ca, di, ra;
    if (!rst_ni) begin
      chk("rst_cpu_ack", cpu_ack_o, 0);
      chk("rst_cpu_err", cpu_err_o, 0);
      chk("rst_disp_valid", disp_valid_o, 0);
      chk("rst_cpu_rdata", cpu_rdata_o, 0);
      chk("rst_disp_rdata", disp_rdata_o, 0);
      chk("rst_ram_en", ram_en_o, 0);
      chk("rst_ram_we", ram_we_o, 0);
      pend_cpu  = 1'b0;
      pend_disp = 1'b0;
    end else begin
      chk("m_cpu_ack", cpu_ack_o, pend_cpu);
      chk("m_cpu_err", cpu_err_o, pend_cpu && pend_cpu_err);
      if (!pend_cpu || pend_cpu_chk) chk("m_cpu_rdata", cpu_rdata_o, pend_cpu ? pend_cpu_data : 0);
      chk("m_disp_valid", disp_valid_o, pend_disp);
      chk("m_disp_rdata", disp_rdata_o, pend_disp ? pend_disp_data : 0);

      g_disp = disp_req_i && !pend_disp;
      g_cpu  = cpu_req_i && !pend_cpu && !g_disp;
      ca     = 32'(cpu_addr_i);
      di     = 32'(disp_idx_i);
      c_in   = (ca >= OrigBase) && (ca < RegEnd);
      d_in   = di < ImgSize;
      exp_en = (g_disp && d_in) || (g_cpu && c_in);
      exp_we = g_cpu && c_in && cpu_we_i;
      if (g_disp && d_in) ra = di + (disp_sel_i ? ImgSize : 0);
      else if (g_cpu && c_in) ra = ca - OrigBase;
      else ra = 0;

      chk("m_ram_en", ram_en_o, exp_en);
      if (!(g_cpu && !c_in)) chk("m_ram_we", ram_we_o, exp_we);
      if (exp_en || (!g_cpu && !g_disp)) chk("m_ram_addr", ram_addr_o, ra);
      if (exp_we || (!g_cpu && !g_disp)) chk("m_ram_wdata", ram_wdata_o, exp_we ? cpu_wdata_i : 0);
      if (exp_we) shadow[ra] = cpu_wdata_i;

      pend_disp      = g_disp;
      pend_disp_data = (g_disp && d_in) ? shadow[ra] : 8'h00;
      pend_cpu       = g_cpu;
      pend_cpu_err   = !c_in;
      pend_cpu_chk   = !cpu_we_i || !c_in;
      pend_cpu_data  = (g_cpu && c_in && !cpu_we_i) ? shadow[ca - OrigBase] : 8'h00;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  function automatic logic [23:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return 24'd119;
      1: return 24'd120;
      2: return 24'd320119;
      3: return 24'd320120;
      4: return 24'd96;
      5: return 24'd160119;
      6: return 24'd160120;
      7: return 24'($urandom_range(RegEnd, 24'hFFFFFF));
      default: return 24'($urandom_range(OrigBase, RegEnd - 1));
    endcase
  endfunction

  function automatic logic [17:0] pick_idx();
    case ($urandom_range(0, 9))
      0: return 18'd159999;
      1: return 18'd160000;
      2: return 18'($urandom_range(ImgSize, 18'h3FFFF));
      default: return 18'($urandom_range(0, ImgSize - 1));
    endcase
  endfunction

  initial begin
    int nd, nc, consec, wc;
    logic prev_d, prev_c, cpu_fin, disp_fin;

    for (int i = 0; i < MemWords; i++) begin
      mem[i]    = 8'($urandom);
      shadow[i] = mem[i];
    end
    mem[0]    = 8'h5A;
    shadow[0] = 8'h5A;

    // Reset state.
    at_neg();
    chk("reset_cpu_ack", cpu_ack_o, 0);
    chk("reset_disp_valid", disp_valid_o, 0);
    chk("reset_ram_en", ram_en_o, 0);
    at_neg();
    tick();
    rst_ni = 1'b1;

    // CPU read at the first original-image address.
    tick();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 24'd120;
    at_neg();
    chk("rd_grant_en", ram_en_o, 1);
    chk("rd_grant_addr", ram_addr_o, 0);
    tick(); at_neg();
    chk("rd_ack", cpu_ack_o, 1);
    chk("rd_data", cpu_rdata_o, 8'h5A);
    chk("rd_err", cpu_err_o, 0);

    // CPU write at the first processed-image address, then display read-back.
    tick();
    cpu_we_i = 1'b1; cpu_addr_i = 24'd160120; cpu_wdata_i = 8'h33;
    at_neg();
    chk("wr_we", ram_we_o, 1);
    chk("wr_addr", ram_addr_o, 160000);
    chk("wr_wdata", ram_wdata_o, 8'h33);
    tick(); at_neg();
    chk("wr_ack", cpu_ack_o, 1);
    tick();
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    disp_req_i = 1'b1; disp_sel_i = 1'b1; disp_idx_i = '0;
    at_neg();
    chk("drd_en", ram_en_o, 1);
    chk("drd_addr", ram_addr_o, 160000);
    tick(); at_neg();
    chk("drd_valid", disp_valid_o, 1);
    chk("drd_data", disp_rdata_o, 8'h33);

    // Both requesting together for 8 cycles.
    tick();
    cpu_req_i = 1'b1; cpu_addr_i = 24'd120;
    disp_req_i = 1'b1; disp_sel_i = 1'b0; disp_idx_i = 18'd5;
    nd = 0; nc = 0; consec = 0; prev_d = 1'b0; prev_c = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        tick();
        if (k == 8) begin cpu_req_i = 1'b0; disp_req_i = 1'b0; end
      end
      at_neg();
      if (k == 1) begin
        chk("both_first_disp", disp_valid_o, 1);
        chk("both_first_cpu", cpu_ack_o, 0);
      end
      if ((disp_valid_o && prev_d) || (cpu_ack_o && prev_c)) consec++;
      prev_d = disp_valid_o; prev_c = cpu_ack_o;
      nd += int'(disp_valid_o); nc += int'(cpu_ack_o);
    end
    chk("both_disp_cnt", nd, 4);
    chk("both_cpu_cnt", nc, 4);
    chk("both_no_repeat", consec, 0);

    // Out-of-range CPU addresses below and above the image regions.
    tick();
    wc = ram_wr_cnt;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 24'd96;
    at_neg();
    chk("oor_lo_en", ram_en_o, 0);
    tick(); at_neg();
    chk("oor_lo_ack", cpu_ack_o, 1);
    chk("oor_lo_err", cpu_err_o, 1);
    chk("oor_lo_data", cpu_rdata_o, 0);
    tick();
    cpu_we_i = 1'b1; cpu_addr_i = 24'd320120; cpu_wdata_i = 8'hEE;
    at_neg();
    chk("oor_hi_en", ram_en_o, 0);
    tick(); at_neg();
    chk("oor_hi_ack", cpu_ack_o, 1);
    chk("oor_hi_err", cpu_err_o, 1);
    tick();
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    chk("oor_no_write", ram_wr_cnt, wc);

    // Display index just past the image.
    disp_req_i = 1'b1; disp_sel_i = 1'b0; disp_idx_i = 18'd160000;
    at_neg();
    chk("door_en", ram_en_o, 0);
    tick(); at_neg();
    chk("door_valid", disp_valid_o, 1);
    chk("door_data", disp_rdata_o, 0);

    // Reset landing on the cycle after a CPU read grant.
    tick();
    disp_req_i = 1'b0;
    cpu_req_i = 1'b1; cpu_addr_i = 24'd120;
    at_neg();
    chk("rstmid_grant_en", ram_en_o, 1);
    tick();
    rst_ni = 1'b0;
    at_neg();
    chk("rstmid_no_ack", cpu_ack_o, 0);
    chk("rstmid_rdata", cpu_rdata_o, 0);
    chk("rstmid_ram_en", ram_en_o, 0);
    tick();
    rst_ni = 1'b1;
    at_neg();
    chk("rstrel_grant_en", ram_en_o, 1);
    chk("rstrel_grant_addr", ram_addr_o, 0);
    tick(); at_neg();
    chk("rstrel_ack", cpu_ack_o, 1);
    chk("rstrel_data", cpu_rdata_o, 8'h5A);
    tick();
    cpu_req_i = 1'b0;

    // Randomized traffic; requests held until completed, one mid-run reset.
    cpu_fin = 1'b0; disp_fin = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (!cpu_req_i || cpu_fin) begin
        if ($urandom_range(0, 2) != 0) begin
          cpu_req_i   = 1'b1;
          cpu_we_i    = 1'($urandom_range(0, 1));
          cpu_addr_i  = pick_addr();
          cpu_wdata_i = 8'($urandom);
        end else begin
          cpu_req_i = 1'b0;
        end
      end
      cpu_fin = cpu_ack_o;
      if (!disp_req_i || disp_fin) begin
        if ($urandom_range(0, 2) != 0) begin
          disp_req_i = 1'b1;
          disp_sel_i = 1'($urandom_range(0, 1));
          disp_idx_i = pick_idx();
        end else begin
          disp_req_i = 1'b0;
        end
      end
      disp_fin = disp_valid_o;
      if (c == 2000) rst_ni = 1'b0;
      if (c == 2002) rst_ni = 1'b1;
    end

    tick();
    cpu_req_i = 1'b0; disp_req_i = 1'b0;
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
